mm_result_drain: RTL and testbench
==================================

// Module: mm_result_drain
// PURPOSE
//  Responder on the op_start/op_busy/op_done handshake: the read-out end of the
//  matrix-multiply result path. On start it snapshots a flattened M_DIM x N_DIM
//  accumulator matrix C and streams it element by element, row-major, over a
//  valid/ready port toward the writeback/next transformer stage.
//  Width-reduces each element from ACCUM_WIDTH to OUT_WIDTH.
// PARAMETERS
//  ACCUM_WIDTH  32  signed width of each input element of C
//  OUT_WIDTH    16  signed width of each streamed element (<= ACCUM_WIDTH)
//  M_DIM        2   rows of C
//  N_DIM        2   cols of C
// PORTS
//  clk                 in   1                    rising-edge clock, single domain
//  rst                 in   1                    async reset, active-high
//  op_start_drain      in   1                    1-cycle start request
//  matrix_c_flat_in    in   M_DIM*N_DIM*ACCUM_WIDTH  C; element (m,n) at [(m*N_DIM+n)*ACCUM_WIDTH +: ACCUM_WIDTH]
//  m_valid             out  1                    stream element valid
//  m_ready             in   1                    downstream accepts element
//  m_data              out  OUT_WIDTH            signed element value
//  m_row               out  clog2(M_DIM) (min 1) row index of m_data
//  m_col               out  clog2(N_DIM) (min 1) col index of m_data
//  m_last              out  1                    high with final element (M_DIM-1,N_DIM-1)
//  op_busy_drain       out  1                    high from start capture through final handshake
//  op_done_drain       out  1                    1-cycle pulse after final handshake
// BEHAVIOUR
//  - Reset (async, rst=1): state IDLE; m_valid, m_last, op_busy_drain, op_done_drain,
//    m_data, m_row, m_col all 0; internal buffer and counters cleared. Applies mid-stream:
//    stream aborted, no done pulse.
//  - FSM IDLE -> STREAM -> IDLE.
//  - IDLE: op_start_drain=1 at edge k captures all of matrix_c_flat_in into internal buffer;
//    after edge k: state STREAM, op_busy_drain=1, m_valid=1, element (0,0) presented.
//  - STREAM: handshake = m_valid & m_ready at rising edge. While m_valid & !m_ready,
//    m_data/m_row/m_col/m_last held stable. On handshake, index advances col-first
//    (col wraps N_DIM-1 -> 0, row increments); next element presented next cycle, no bubble.
//  - Final handshake (row=M_DIM-1, col=N_DIM-1, m_last=1) at edge j: after edge j m_valid=0,
//    m_last=0, op_busy_drain=0, op_done_drain=1 for exactly one cycle, state IDLE.
//  - op_start_drain while STREAM: ignored, buffer unchanged. op_start_drain in the
//    op_done_drain cycle: accepted (state already IDLE), new capture.
//  - Input matrix changes after capture do not affect the stream.
//  - Latency with m_ready=1: first element visible 1 cycle after start; done pulse
//    M_DIM*N_DIM+1 cycles after start edge.
//  - m_ready ignored while m_valid=0.
//  - Width reduction: element is signed two's complement; see CONFIGURATION.
// CONFIGURATION
//  MM_DRAIN_SAT_EN defined: each element saturates to OUT_WIDTH signed range
//    [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]; in-range values pass unchanged.
//  MM_DRAIN_SAT_EN undefined: m_data = low OUT_WIDTH bits of element (wrap, no clamp).
// TESTING
//  1. C=[[31,19],[85,55]], m_ready=1, 1-cycle start -> beats 31,19,85,55 on consecutive
//     cycles, (row,col)=(0,0),(0,1),(1,0),(1,1), m_last only on 55, done 1 cycle later.
//  2. Same C, m_ready toggles 1,0,0,1,0,1,... -> identical beat order, m_data stable during
//     stalls, busy high until final handshake, exactly one done pulse.
//  3. C[0][0]=70000, C[0][1]=-40000 -> with MM_DRAIN_SAT_EN: 32767, -32768;
//     without: 4464, 25536.
//  4. rst=1 after 2nd handshake -> outputs 0 immediately (async), no done; fresh start
//     afterwards streams from (0,0).
//  5. Start pulse during STREAM with different C -> ignored, original values stream;
//     start in done cycle -> new capture, first beat next cycle.
//  6. Change matrix_c_flat_in one cycle after start -> streamed values match captured C.

Source files
------------

// File: rtl/mm_result_drain.sv
// ---------------------------------------------------------------------------
// mm_result_drain
//
// Read-out end of the matrix-multiply result path. A one-cycle start request
// snapshots the flattened M_DIM x N_DIM accumulator matrix C. The block then
// streams the snapshot one element at a time, row-major, over a valid/ready
// port. Each element is width-reduced from ACCUM_WIDTH to OUT_WIDTH.
//
// Build option:
//   MM_DRAIN_SAT_EN  defined   -> each element saturates to the signed
//                                 OUT_WIDTH range
//                    undefined -> each element keeps its low OUT_WIDTH bits
//                                 (two's-complement wrap)
//
// Ports:
//   clk               rising-edge clock
//   rst               asynchronous reset, active high
//   op_start_drain    one-cycle start request (ignored while streaming)
//   matrix_c_flat_in  C; element (m,n) at [(m*N_DIM+n)*ACCUM_WIDTH +: ACCUM_WIDTH]
//   m_valid/m_ready   stream handshake
//   m_data            width-reduced signed element
//   m_row/m_col       index of the element on m_data
//   m_last            marks element (M_DIM-1, N_DIM-1)
//   op_busy_drain     high from capture through the final handshake
//   op_done_drain     one-cycle pulse after the final handshake
// ---------------------------------------------------------------------------

// Per-element width reduction. The drain instantiates one of these for every
// element, so the buffer only ever holds OUT_WIDTH-wide values.
module mm_drain_lane #(
    parameter int ACCUM_WIDTH = 32,
    parameter int OUT_WIDTH   = 16
) (
    input  logic [ACCUM_WIDTH-1:0] acc,
    output logic [OUT_WIDTH-1:0]   q
);
    generate
        if (OUT_WIDTH == ACCUM_WIDTH) begin : g_pass
            assign q = acc;
        end else begin : g_reduce
`ifdef MM_DRAIN_SAT_EN
            // The value fits in OUT_WIDTH signed bits exactly when the
            // discarded bits and the new sign bit all match.
            localparam int HB = ACCUM_WIDTH - OUT_WIDTH + 1;
            logic [HB-1:0] hi;
            logic          fits;
            assign hi   = acc[ACCUM_WIDTH-1 -: HB];
            assign fits = (hi == '0) || (hi == '1);
            always_comb begin
                if (fits)
                    q = acc[OUT_WIDTH-1:0];
                else if (acc[ACCUM_WIDTH-1])
                    q = {1'b1, {(OUT_WIDTH-1){1'b0}}};
                else
                    q = {1'b0, {(OUT_WIDTH-1){1'b1}}};
            end
`else
            // Wrap mode discards the upper bits.
            logic unused_hi;
            assign unused_hi = ^acc[ACCUM_WIDTH-1:OUT_WIDTH];
            assign q         = acc[OUT_WIDTH-1:0];
`endif
        end
    endgenerate
endmodule

module mm_result_drain #(
    parameter int ACCUM_WIDTH = 32,
    parameter int OUT_WIDTH   = 16,
    parameter int M_DIM       = 2,
    parameter int N_DIM       = 2,
    localparam int RW = (M_DIM > 1) ? $clog2(M_DIM) : 1,
    localparam int CW = (N_DIM > 1) ? $clog2(N_DIM) : 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               op_start_drain,
    input  logic [M_DIM*N_DIM*ACCUM_WIDTH-1:0] matrix_c_flat_in,
    output logic                               m_valid,
    input  logic                               m_ready,
    output logic [OUT_WIDTH-1:0]               m_data,
    output logic [RW-1:0]                      m_row,
    output logic [CW-1:0]                      m_col,
    output logic                               m_last,
    output logic                               op_busy_drain,
    output logic                               op_done_drain
);
    localparam int NUM_EL = M_DIM * N_DIM;
    localparam int IW     = (NUM_EL > 1) ? $clog2(NUM_EL) : 1;

    localparam logic [RW-1:0] ROW_LAST = RW'(M_DIM - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(N_DIM - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_EL - 1);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } state_t;

    state_t state_q, state_d;

    // The flat index selects from the buffer. Row and column are kept as
    // separate counters so the index outputs never need a divider.
    logic [IW-1:0] idx_q, idx_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic          done_q, done_d;
    logic          cap_en;
    logic          at_last;

    logic [NUM_EL-1:0][OUT_WIDTH-1:0] red_in;
    logic [NUM_EL-1:0][OUT_WIDTH-1:0] buf_q;

    // Width reduction runs ahead of the snapshot, so the buffer stores
    // values that are ready to send.
    generate
        for (genvar e = 0; e < NUM_EL; e++) begin : g_lane
            mm_drain_lane #(
                .ACCUM_WIDTH (ACCUM_WIDTH),
                .OUT_WIDTH   (OUT_WIDTH)
            ) u_lane (
                .acc (matrix_c_flat_in[e*ACCUM_WIDTH +: ACCUM_WIDTH]),
                .q   (red_in[e])
            );
        end
    endgenerate

    // The row and column counters move in lockstep with idx_q, so one
    // compare on the flat index detects the final element.
    assign at_last = (idx_q == IDX_LAST);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        row_d   = row_q;
        col_d   = col_q;
        done_d  = 1'b0;
        cap_en  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (op_start_drain) begin
                    cap_en  = 1'b1;
                    state_d = S_STREAM;
                    idx_d   = '0;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            S_STREAM: begin
                if (m_ready) begin
                    if (at_last) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                        idx_d   = '0;
                        row_d   = '0;
                        col_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                        if (col_q == COL_LAST) begin
                            col_d = '0;
                            row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
                        end else begin
                            col_d = col_q + 1'b1;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            row_q   <= row_d;
            col_q   <= col_d;
            done_q  <= done_d;
        end
    end

    // The snapshot is taken only when a start is accepted from idle. A start
    // that arrives while streaming, or any later change to the input, does
    // not reach the stream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            buf_q <= '0;
        else if (cap_en)
            buf_q <= red_in;
    end

    // The stream outputs are gated by m_valid. This keeps them at zero in
    // idle, and they hold steady during a stall because only a handshake
    // moves idx_q.
    assign m_valid       = (state_q == S_STREAM);
    assign m_data        = m_valid ? buf_q[idx_q] : '0;
    assign m_row         = m_valid ? row_q : '0;
    assign m_col         = m_valid ? col_q : '0;
    assign m_last        = m_valid & at_last;
    assign op_busy_drain = m_valid;
    assign op_done_drain = done_q;

endmodule

// File: tb/tb_mm_result_drain.sv
// ---------------------------------------------------------------------------
// tb_mm_result_drain
//
// Drives directed scenarios and then random ones into mm_result_drain. A
// monitor holds a transaction-level model of the drain: the captured matrix,
// the current stream position and a done flag. Every cycle, the monitor
// compares all DUT outputs against that model. Literal tables of expected
// beats and the done latency check the model for the directed cases.
// Honours MM_DRAIN_SAT_EN in the same way as the design.
// ---------------------------------------------------------------------------
module tb_mm_result_drain;
    localparam int AW     = 32;
    localparam int OW     = 16;
    localparam int MD     = 2;
    localparam int ND     = 2;
    localparam int NUM_EL = MD * ND;
    localparam int RW     = (MD > 1) ? $clog2(MD) : 1;
    localparam int CW     = (ND > 1) ? $clog2(ND) : 1;
    localparam int VW     = 4 + OW + RW + CW;

    localparam longint MAXV = (64'sd1 <<< (OW - 1)) - 1;
    localparam longint MINV = -(64'sd1 <<< (OW - 1));

    logic                   clk_tb;
    logic                   rst;
    logic                   op_start_drain;
    logic [NUM_EL*AW-1:0]   matrix_c_flat_in;
    logic                   m_valid;
    logic                   m_ready;
    logic [OW-1:0]          m_data;
    logic [RW-1:0]          m_row;
    logic [CW-1:0]          m_col;
    logic                   m_last;
    logic                   op_busy_drain;
    logic                   op_done_drain;

    mm_result_drain #(
        .ACCUM_WIDTH (AW),
        .OUT_WIDTH   (OW),
        .M_DIM       (MD),
        .N_DIM       (ND)
    ) dut (
        .clk              (clk_tb),
        .rst              (rst),
        .op_start_drain   (op_start_drain),
        .matrix_c_flat_in (matrix_c_flat_in),
        .m_valid          (m_valid),
        .m_ready          (m_ready),
        .m_data           (m_data),
        .m_row            (m_row),
        .m_col            (m_col),
        .m_last           (m_last),
        .op_busy_drain    (op_busy_drain),
        .op_done_drain    (op_done_drain)
    );

    initial clk_tb = 1'b0;
    always #5 clk_tb = ~clk_tb;

    int n_cmp  = 0;
    int n_fail = 0;
    int lit_sel = 0;     // literal beat table for the next accepted start (0: none)
    int lit_lat = 0;     // expected start-to-done latency (0: not checked)

    // Model of the spec rules for width reduction, written as signed
    // arithmetic on the element value.
    function automatic logic [OW-1:0] reduce(input logic [AW-1:0] raw);
        longint v;
        v = longint'($signed(raw));
`ifdef MM_DRAIN_SAT_EN
        if (v > MAXV) v = MAXV;
        else if (v < MINV) v = MINV;
`else
        v = v % (64'sd1 <<< OW);
        if (v < 0) v = v + (64'sd1 <<< OW);
`endif
        return v[OW-1:0];
    endfunction

    function automatic logic [OW-1:0] lit_val(input int sel, input int e);
        logic [OW-1:0] r;
        r = '0;
        case (sel)
            1: case (e) 0: r = OW'(31); 1: r = OW'(19); 2: r = OW'(85); default: r = OW'(55); endcase
            2: case (e) 0: r = OW'(1);  1: r = OW'(2);  2: r = OW'(3);  default: r = OW'(4);  endcase
`ifdef MM_DRAIN_SAT_EN
            3: case (e) 0: r = OW'(32767); 1: r = OW'(-32768); 2: r = OW'(1); default: r = OW'(-1); endcase
`else
            3: case (e) 0: r = OW'(4464);  1: r = OW'(25536);  2: r = OW'(1); default: r = OW'(-1); endcase
`endif
            default: r = '0;
        endcase
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", nm, $time, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor and model. The monitor samples 1ns after each falling edge
    // and compares first. It then advances the model using the inputs
    // that the next rising edge will sample.
    // ------------------------------------------------------------------
    initial begin : monitor
        bit            act;
        int            pos;
        bit            done;
        int            cyc;
        int            start_cyc;
        int            cur_lit;
        int            cur_lat;
        logic [OW-1:0] mat [NUM_EL];
        logic [OW-1:0] beat_log [$];
        logic [VW-1:0] exp_v, got_v;
        logic [OW-1:0] e_data, g_data;
        logic [RW-1:0] e_row, g_row;
        logic [CW-1:0] e_col, g_col;
        bit            done_n;
        act = 0; pos = 0; done = 0; cyc = 0; start_cyc = 0; cur_lit = 0; cur_lat = 0;
        for (int e = 0; e < NUM_EL; e++) mat[e] = '0;
        forever begin
            @(negedge clk_tb or posedge rst);
            #1;
            if (rst) begin
                act = 0; pos = 0; done = 0; cur_lit = 0; cur_lat = 0;
                beat_log.delete();
                chk("reset_outputs_zero",
                    64'({m_valid, m_last, op_busy_drain, op_done_drain, m_data, m_row, m_col}),
                    64'(0));
            end else begin
                cyc++;
                e_data = act ? mat[pos] : '0;
                e_row  = act ? RW'(pos / ND) : '0;
                e_col  = act ? CW'(pos % ND) : '0;
                g_data = act ? m_data : '0;
                g_row  = act ? m_row : '0;
                g_col  = act ? m_col : '0;
                exp_v  = {act, act && (pos == NUM_EL - 1), act, done, e_data, e_row, e_col};
                got_v  = {m_valid, m_last, op_busy_drain, op_done_drain, g_data, g_row, g_col};
                chk("cycle_outputs", 64'(got_v), 64'(exp_v));

                if (done && cur_lit != 0) begin
                    chk("lit_beat_count", 64'(beat_log.size()), 64'(NUM_EL));
                    for (int i = 0; i < beat_log.size() && i < NUM_EL; i++)
                        chk($sformatf("lit%0d_beat%0d", cur_lit, i), 64'(beat_log[i]), 64'(lit_val(cur_lit, i)));
                    if (cur_lat != 0)
                        chk("done_latency", 64'(cyc - start_cyc), 64'(cur_lat));
                    cur_lit = 0;
                end

                done_n = 0;
                if (act) begin
                    if (m_ready) begin
                        beat_log.push_back(mat[pos]);
                        if (pos == NUM_EL - 1) begin
                            act    = 0;
                            done_n = 1;
                        end else begin
                            pos++;
                        end
                    end
                end else if (op_start_drain) begin
                    for (int e = 0; e < NUM_EL; e++)
                        mat[e] = reduce(matrix_c_flat_in[e*AW +: AW]);
                    act       = 1;
                    pos       = 0;
                    start_cyc = cyc;
                    cur_lit   = lit_sel;
                    cur_lat   = lit_lat;
                    beat_log.delete();
                end
                done = done_n;
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver: changes inputs 1ns after each rising edge.
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk_tb);
        #1;
    endtask

    task automatic set_el(input int e, input int v);
        matrix_c_flat_in[e*AW +: AW] = AW'(v);
    endtask

    task automatic load4(input int a, input int b, input int c, input int d);
        set_el(0, a); set_el(1, b); set_el(2, c); set_el(3, d);
    endtask

    task automatic start_pulse();
        op_start_drain = 1'b1;
        tick();
        op_start_drain = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            tick();
            if (op_done_drain) return;
        end
        $display("FAIL wait_done @%0t: got no op_done_drain within %0d cycles", $time, budget);
        $fatal(1, "timeout");
    endtask

    task automatic rand_c();
        int v;
        for (int e = 0; e < NUM_EL; e++) begin
            case ($urandom_range(0, 3))
                0: v = int'($urandom_range(0, 200)) - 100;
                1: v = int'($urandom);
                2: v = 32767 + int'($urandom_range(0, 4)) - 2;
                default: v = -32768 + int'($urandom_range(0, 4)) - 2;
            endcase
            set_el(e, v);
        end
    endtask

    initial begin : driver
        int pat [6] = '{1, 0, 0, 1, 0, 1};
        bit got_done;
        rst = 1'b1;
        op_start_drain = 1'b0;
        m_ready = 1'b0;
        matrix_c_flat_in = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // 1: plain stream with m_ready held high
        load4(31, 19, 85, 55);
        m_ready = 1'b1; lit_sel = 1; lit_lat = NUM_EL + 1;
        start_pulse();
        wait_done(20);
        repeat (2) tick();

        // 2: back-pressure pattern
        lit_sel = 1; lit_lat = 0;
        start_pulse();
        got_done = 0;
        for (int i = 0; i < 40 && !got_done; i++) begin
            m_ready = pat[i % 6][0];
            tick();
            got_done = op_done_drain;
        end
        if (!got_done) begin
            $display("FAIL stall_stream_done @%0t: got no done, expected one", $time);
            $fatal(1, "timeout");
        end
        m_ready = 1'b1;
        repeat (2) tick();

        // 3: width reduction at the range boundaries
        load4(70000, -40000, 1, -1);
        lit_sel = 3; lit_lat = NUM_EL + 1;
        start_pulse();
        wait_done(20);
        tick();

        // 4: reset after the second handshake, then a fresh start
        load4(31, 19, 85, 55);
        lit_sel = 0; lit_lat = 0;
        start_pulse();
        repeat (2) tick();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        lit_sel = 1; lit_lat = NUM_EL + 1;
        start_pulse();
        wait_done(20);
        tick();

        // 5: start while streaming is ignored, start in the done cycle is taken
        lit_sel = 1; lit_lat = NUM_EL + 1;
        start_pulse();
        tick();
        load4(1, 2, 3, 4);
        start_pulse();
        wait_done(20);
        lit_sel = 2; lit_lat = NUM_EL + 1;
        start_pulse();
        wait_done(20);
        tick();

        // 6: input changes after capture do not reach the stream
        load4(31, 19, 85, 55);
        lit_sel = 1; lit_lat = NUM_EL + 1;
        start_pulse();
        load4(-5, -6, -7, -8);
        wait_done(20);
        tick();

        // Random traffic
        lit_sel = 0; lit_lat = 0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 149) == 0) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end
            if ($urandom_range(0, 3) == 0) rand_c();
            op_start_drain = ($urandom_range(0, 5) == 0);
            m_ready = ($urandom_range(0, 9) < 7);
            tick();
            op_start_drain = 1'b0;
        end
        m_ready = 1'b1;
        repeat (12) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
